// File: rtl/jk_ff_mon_pkg.sv
// Shared types and the golden JK next-state function for the JK flip-flop monitor.
package jk_ff_mon_pkg;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_RST  = 2'b01,
        OP_SET  = 2'b10,
        OP_TOG  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SYNC  = 2'b01,
        CHECK = 2'b10
    } state_e;

    function automatic logic jk_next(input logic q, input op_e op);
        logic nq;
        case (op)
            OP_HOLD: nq = q;
            OP_RST:  nq = 1'b0;
            OP_SET:  nq = 1'b1;
            OP_TOG:  nq = ~q;
            default: nq = q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/jk_ff_monitor_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] MAX_C = {W{1'b1}};

    logic [W-1:0] cnt_r;

    // Count register: clear wins over increment, increment stops at MAX_C.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= {W{1'b0}};
        end else if (clr) begin
            cnt_r <= {W{1'b0}};
        end else if (inc && (cnt_r != MAX_C)) begin
            cnt_r <= cnt_r + W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/jk_ff_monitor.sv
// Passive JK flip-flop checker: golden model, per-cycle compare, pass/fail report.
// Optional op histogram counters are built when JK_FF_MONITOR_HIST_EN is defined.
module jk_ff_monitor
    import jk_ff_mon_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int N_CHECKS = 64
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             j,
    input  logic             k,
    input  logic             q,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err_flag,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt
`ifdef JK_FF_MONITOR_HIST_EN
    ,
    output logic [CNT_W-1:0] hold_cnt,
    output logic [CNT_W-1:0] rst_cnt,
    output logic [CNT_W-1:0] set_cnt,
    output logic [CNT_W-1:0] tog_cnt
`endif
);

    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(N_CHECKS - 1);

    state_e           state_r;
    state_e           state_nxt_s;
    logic             exp_q_r;
    logic             exp_vld_r;
    logic             busy_r;
    logic             done_r;
    logic             pass_r;
    logic             err_flag_r;
    logic [CNT_W-1:0] chk_cnt_r;
    logic [CNT_W-1:0] err_cnt_s;

    op_e              op_s;
    logic             sync_op_s;
    logic             start_ok_s;
    logic             clr_s;
    logic             in_check_s;
    logic             mismatch_s;
    logic             last_chk_s;

    assign op_s       = op_e'({j, k});
    assign sync_op_s  = j ^ k;
    // A start coinciding with the done pulse belongs to the run that just ended.
    assign start_ok_s = start && !done_r;
    assign clr_s      = (state_r == IDLE) && start_ok_s;
    assign in_check_s = (state_r == CHECK);
    // Case inequality so an X/Z on q is reported rather than silently matching.
    assign mismatch_s = in_check_s && exp_vld_r && (q !== exp_q_r);
    assign last_chk_s = in_check_s && (chk_cnt_r == LAST_C);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_ok_s) state_nxt_s = SYNC;
                else            state_nxt_s = IDLE;
            end
            SYNC: begin
                if (sync_op_s) state_nxt_s = CHECK;
                else           state_nxt_s = SYNC;
            end
            CHECK: begin
                if (last_chk_s) state_nxt_s = IDLE;
                else            state_nxt_s = CHECK;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Golden model, check counter and registered status outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            exp_q_r    <= 1'b0;
            exp_vld_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            err_flag_r <= 1'b0;
            chk_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            busy_r <= (state_nxt_s != IDLE);
            done_r <= last_chk_s;
            case (state_r)
                IDLE: begin
                    if (start_ok_s) begin
                        chk_cnt_r  <= {CNT_W{1'b0}};
                        err_flag_r <= 1'b0;
                        pass_r     <= 1'b0;
                        exp_vld_r  <= 1'b0;
                    end
                end
                SYNC: begin
                    if (sync_op_s) begin
                        exp_q_r   <= jk_next(exp_q_r, op_s);
                        exp_vld_r <= 1'b1;
                    end
                end
                CHECK: begin
                    chk_cnt_r <= chk_cnt_r + CNT_W'(1);
                    exp_q_r   <= jk_next(exp_q_r, op_s);
                    if (mismatch_s) err_flag_r <= 1'b1;
                    if (last_chk_s) pass_r <= (err_cnt_s == {CNT_W{1'b0}}) && !mismatch_s;
                end
                default: begin
                    exp_vld_r <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (clr_s),
        .inc     (mismatch_s),
        .cnt     (err_cnt_s)
    );

`ifdef JK_FF_MONITOR_HIST_EN
    sat_counter #(.W(CNT_W)) u_hold_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (clr_s),
        .inc     (in_check_s && (op_s == OP_HOLD)),
        .cnt     (hold_cnt)
    );

    sat_counter #(.W(CNT_W)) u_rst_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (clr_s),
        .inc     (in_check_s && (op_s == OP_RST)),
        .cnt     (rst_cnt)
    );

    sat_counter #(.W(CNT_W)) u_set_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (clr_s),
        .inc     (in_check_s && (op_s == OP_SET)),
        .cnt     (set_cnt)
    );

    sat_counter #(.W(CNT_W)) u_tog_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (clr_s),
        .inc     (in_check_s && (op_s == OP_TOG)),
        .cnt     (tog_cnt)
    );
`endif

    assign busy     = busy_r;
    assign done     = done_r;
    assign pass     = pass_r;
    assign err_flag = err_flag_r;
    assign chk_cnt  = chk_cnt_r;
    assign err_cnt  = err_cnt_s;

endmodule

// File: tb/tb_jk_ff_monitor.sv
// Self-checking bench: two monitors (8-check/16-bit and 15-check/4-bit) against a behavioural model.
module tb_jk_ff_monitor;

    localparam int NA = 8;
    localparam int WA = 16;
    localparam int NB = 15;
    localparam int WB = 4;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic j = 1'b0, k = 1'b0;
    logic start_a = 1'b0, start_b = 1'b0;
    logic inv_a = 1'b0, xq_a = 1'b0;
    logic jk_q;
    logic q_a, q_b;

    logic          busy_a, done_a, pass_a, flag_a;
    logic [WA-1:0] chk_a, err_a;
    logic          busy_b, done_b, pass_b, flag_b;
    logic [WB-1:0] chk_b, err_b;
`ifdef JK_FF_MONITOR_HIST_EN
    logic [WA-1:0] hold_a, rst_a, set_a, tog_a;
    logic [WB-1:0] hold_b, rst_b, set_b, tog_b;
`endif

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    // Correct JK flip-flop standing in for the design under observation.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) jk_q <= 1'b0;
        else if (j && k) jk_q <= ~jk_q;
        else if (j || k) jk_q <= j;
    end

    assign q_a = xq_a ? 1'bx : (jk_q ^ inv_a);
    assign q_b = ~jk_q;

    jk_ff_monitor #(.CNT_W(WA), .N_CHECKS(NA)) dut_a (
        .clock(clock), .reset_n(reset_n), .start(start_a), .j(j), .k(k), .q(q_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_flag(flag_a),
        .chk_cnt(chk_a), .err_cnt(err_a)
`ifdef JK_FF_MONITOR_HIST_EN
        , .hold_cnt(hold_a), .rst_cnt(rst_a), .set_cnt(set_a), .tog_cnt(tog_a)
`endif
    );

    jk_ff_monitor #(.CNT_W(WB), .N_CHECKS(NB)) dut_b (
        .clock(clock), .reset_n(reset_n), .start(start_b), .j(j), .k(k), .q(q_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_flag(flag_b),
        .chk_cnt(chk_b), .err_cnt(err_b)
`ifdef JK_FF_MONITOR_HIST_EN
        , .hold_cnt(hold_b), .rst_cnt(rst_b), .set_cnt(set_b), .tog_cnt(tog_b)
`endif
    );

    // Behavioural model: phase 0 idle, 1 waiting for a known state, 2 checking.
    int m_phase[2], m_chk[2], m_err[2];
    int m_hist[2][4];
    bit m_exp[2], m_busy[2], m_done[2], m_pass[2], m_flag[2];
    int m_n[2]   = '{NA, NB};
    int m_max[2] = '{(1 << WA) - 1, (1 << WB) - 1};

    always @(posedge clock or negedge reset_n) begin
        logic st, qq;
        bit   was_done;
        int   op;
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                m_phase[i] = 0; m_chk[i] = 0; m_err[i] = 0; m_exp[i] = 0;
                m_busy[i] = 0; m_done[i] = 0; m_pass[i] = 0; m_flag[i] = 0;
                for (int h = 0; h < 4; h++) m_hist[i][h] = 0;
            end else begin
                st = (i == 0) ? start_a : start_b;
                qq = (i == 0) ? q_a : q_b;
                was_done = m_done[i];
                m_done[i] = 0;
                if (m_phase[i] == 0) begin
                    if (st && !was_done) begin
                        m_chk[i] = 0; m_err[i] = 0; m_flag[i] = 0; m_pass[i] = 0;
                        for (int h = 0; h < 4; h++) m_hist[i][h] = 0;
                        m_phase[i] = 1;
                    end
                end else if (m_phase[i] == 1) begin
                    if (j != k) begin
                        m_exp[i] = j;
                        m_phase[i] = 2;
                    end
                end else begin
                    m_chk[i]++;
                    if (qq !== m_exp[i]) begin
                        if (m_err[i] < m_max[i]) m_err[i]++;
                        m_flag[i] = 1;
                    end
                    op = int'({j, k});
                    if (m_hist[i][op] < m_max[i]) m_hist[i][op]++;
                    if (j && k) m_exp[i] = ~m_exp[i];
                    else if (j || k) m_exp[i] = j;
                    if (m_chk[i] == m_n[i]) begin
                        m_done[i] = 1;
                        m_pass[i] = (m_err[i] == 0);
                        m_phase[i] = 0;
                    end
                end
                m_busy[i] = (m_phase[i] != 0);
            end
        end
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both monitors against the model.
    always @(negedge clock) begin
        cmp("busy_a", 32'(busy_a), 32'(m_busy[0]));
        cmp("done_a", 32'(done_a), 32'(m_done[0]));
        cmp("pass_a", 32'(pass_a), 32'(m_pass[0]));
        cmp("flag_a", 32'(flag_a), 32'(m_flag[0]));
        cmp("chk_a", 32'(chk_a), m_chk[0]);
        cmp("err_a", 32'(err_a), m_err[0]);
        cmp("busy_b", 32'(busy_b), 32'(m_busy[1]));
        cmp("done_b", 32'(done_b), 32'(m_done[1]));
        cmp("pass_b", 32'(pass_b), 32'(m_pass[1]));
        cmp("flag_b", 32'(flag_b), 32'(m_flag[1]));
        cmp("chk_b", 32'(chk_b), m_chk[1]);
        cmp("err_b", 32'(err_b), m_err[1]);
`ifdef JK_FF_MONITOR_HIST_EN
        cmp("hold_a", 32'(hold_a), m_hist[0][0]);
        cmp("rst_a", 32'(rst_a), m_hist[0][1]);
        cmp("set_a", 32'(set_a), m_hist[0][2]);
        cmp("tog_a", 32'(tog_a), m_hist[0][3]);
        cmp("hold_b", 32'(hold_b), m_hist[1][0]);
        cmp("rst_b", 32'(rst_b), m_hist[1][1]);
        cmp("set_b", 32'(set_b), m_hist[1][2]);
        cmp("tog_b", 32'(tog_b), m_hist[1][3]);
`endif
    end

    task automatic cyc(input logic jv, input logic kv);
        j = jv;
        k = kv;
        @(negedge clock);
    endtask

    task automatic begin_run_a(input logic jv, input logic kv);
        j = 1'b0; k = 1'b0; start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        cyc(jv, kv);
    endtask

    logic [1:0] clean_ops [8] = '{2'b10, 2'b00, 2'b11, 2'b11, 2'b01, 2'b11, 2'b00, 2'b10};
    logic [1:0] hist_ops  [8] = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b10, 2'b00, 2'b11, 2'b10};

    initial begin
        int ndone;
        logic [1:0] r;
        @(negedge clock);
        @(negedge clock);
        cmp("rst_busy", 32'(busy_a), 32'd0);
        cmp("rst_chk", 32'(chk_a), 32'd0);
        cmp("rst_err", 32'(err_a), 32'd0);
        cmp("rst_pass", 32'(pass_a), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // SYNC gating followed by the clean 8-check run.
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        cmp("sync_busy0", 32'(busy_a), 32'd1);
        cyc(1'b0, 1'b0); cmp("sync_chk00", 32'(chk_a), 32'd0);
        cyc(1'b1, 1'b1); cmp("sync_chk11a", 32'(chk_a), 32'd0);
        cyc(1'b1, 1'b1); cmp("sync_chk11b", 32'(chk_a), 32'd0);
        cmp("sync_busy", 32'(busy_a), 32'd1);
        cyc(1'b1, 1'b0); cmp("sync_exit_chk", 32'(chk_a), 32'd0);
        cyc(clean_ops[0][1], clean_ops[0][0]); cmp("check_first", 32'(chk_a), 32'd1);
        for (int i = 1; i < 8; i++) cyc(clean_ops[i][1], clean_ops[i][0]);
        cmp("clean_done", 32'(done_a), 32'd1);
        cmp("clean_pass", 32'(pass_a), 32'd1);
        cmp("clean_flag", 32'(flag_a), 32'd0);
        cmp("clean_err", 32'(err_a), 32'd0);
        cmp("clean_chk", 32'(chk_a), 32'd8);
        @(negedge clock);
        cmp("clean_pulse", 32'(done_a), 32'd0);

        // Fault injection: three inverted cycles, plus an ignored start mid-run.
        begin_run_a(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            inv_a = (i >= 2 && i < 5);
            start_a = (i == 5);
            r = 2'($urandom_range(0, 3));
            cyc(r[1], r[0]);
            cmp("fault_flag", 32'(flag_a), (i >= 2) ? 32'd1 : 32'd0);
        end
        inv_a = 1'b0; start_a = 1'b0;
        cmp("fault_done", 32'(done_a), 32'd1);
        cmp("fault_err", 32'(err_a), 32'd3);
        cmp("fault_pass", 32'(pass_a), 32'd0);

        // Saturation run on the 4-bit monitor, then start in and after the done cycle.
        j = 1'b0; k = 1'b0; start_b = 1'b1;
        @(negedge clock);
        start_b = 1'b0;
        cyc(1'b1, 1'b0);
        for (int i = 0; i < NB; i++) begin
            r = 2'($urandom_range(0, 3));
            cyc(r[1], r[0]);
        end
        j = 1'b0; k = 1'b0;
        cmp("sat_done", 32'(done_b), 32'd1);
        cmp("sat_err", 32'(err_b), 32'd15);
        cmp("sat_chk", 32'(chk_b), 32'd15);
        start_b = 1'b1;
        @(negedge clock);
        cmp("start_in_done", 32'(busy_b), 32'd0);
        @(negedge clock);
        start_b = 1'b0;
        cmp("restart_busy", 32'(busy_b), 32'd1);
        cmp("restart_err", 32'(err_b), 32'd0);
        cmp("restart_chk", 32'(chk_b), 32'd0);

        // Reset mid-CHECK after 10 checks on the 15-check monitor.
        cyc(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            r = 2'($urandom_range(0, 3));
            cyc(r[1], r[0]);
        end
        cmp("pre_rst_chk", 32'(chk_b), 32'd10);
        #2 reset_n = 1'b0;
        #1;
        cmp("mid_rst_busy", 32'(busy_b), 32'd0);
        cmp("mid_rst_done", 32'(done_b), 32'd0);
        cmp("mid_rst_chk", 32'(chk_b), 32'd0);
        cmp("mid_rst_err", 32'(err_b), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        begin_run_a(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cyc(hist_ops[i][1], hist_ops[i][0]);
        cmp("post_rst_done", 32'(done_a), 32'd1);
        cmp("post_rst_pass", 32'(pass_a), 32'd1);
        cmp("post_rst_chk", 32'(chk_a), 32'd8);
`ifdef JK_FF_MONITOR_HIST_EN
        cmp("hist_hold", 32'(hold_a), 32'd2);
        cmp("hist_rst", 32'(rst_a), 32'd1);
        cmp("hist_set", 32'(set_a), 32'd3);
        cmp("hist_tog", 32'(tog_a), 32'd2);
        cmp("hist_sum", 32'(hold_a) + 32'(rst_a) + 32'(set_a) + 32'(tog_a), 32'(chk_a));
`endif

        // Random traffic: starts at any time, inverted and X cycles on q_a.
        ndone = 0;
        for (int i = 0; i < 600; i++) begin
            r = 2'($urandom_range(0, 3));
            start_a = ($urandom_range(0, 7) == 0);
            start_b = ($urandom_range(0, 7) == 0);
            inv_a = ($urandom_range(0, 9) == 0);
            xq_a = ($urandom_range(0, 29) == 0);
            cyc(r[1], r[0]);
            if (done_a) ndone++;
        end
        start_a = 1'b0; start_b = 1'b0; inv_a = 1'b0; xq_a = 1'b0;
        cmp("random_runs_completed", 32'(ndone > 2), 32'd1);

        @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
